// File: rtl/receiver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : receiver_if
//  Description : Serial line and byte-side strobes of the 8N1 UART receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface receiver_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output frame_error,
        output busy
    );

    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : receiver
//  Description : UART 8N1 receiver (LSB first, one stop bit) with one-cycle
//                data_valid / frame_error strobes. Optional macro
//                UART_RX_MAJORITY_EN selects 2-of-3 majority sampling
//                (needs CLOCK_FREQ / BAUD_RATE >= 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module receiver #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000
) (
    input  wire logic   clk,
    input  wire logic   rst,
    receiver_if.slave   bus
);

    localparam int c_bit_period  = CLOCK_FREQ / BAUD_RATE;
    localparam int c_half_period = c_bit_period / 2;
    localparam int c_cnt_w       = $clog2(c_bit_period) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_prev;
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shreg;
    logic [7:0]         r_data_out;
    logic               r_data_valid;
    logic               r_frame_error;
    logic               r_busy;

    logic               w_sample;
    logic               w_start_hit;
    logic               w_bit_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= bus.rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Votes on rx_s at target-1, target, target+1. Only the START decision moves
    // one cycle later; every later sample inherits the shift through the bit cadence.
    localparam int c_lag = 1;

    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    localparam int c_lag = 0;

    assign w_sample = r_rx_s;
`endif

    assign w_start_hit = (r_cnt == c_cnt_w'(c_half_period - 1 + c_lag));
    assign w_bit_hit   = (r_cnt == c_cnt_w'(c_bit_period - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= 3'd0;
            r_shreg       <= 8'h00;
            r_data_out    <= 8'h00;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // Edge-triggered so a line stuck low cannot start a new frame.
                    if (r_rx_prev && !r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_start_hit) begin
                        r_cnt <= '0;
                        if (!w_sample) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_hit) begin
                        r_cnt     <= '0;
                        r_shreg   <= {w_sample, r_shreg[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_hit) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_sample) begin
                            r_data_out   <= r_shreg;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire
